// File: rtl/ctrl_pkg.sv
// ctrl_pkg: controller state encoding and wait-counter sizing.
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_TRAP
    } ctrl_state_t;
    localparam int MEM_LATENCY_MAX = 15;
    localparam int WAIT_W = $clog2(MEM_LATENCY_MAX + 1);
endpackage

// File: rtl/rv32i_opcodes.sv
// rv32i_opcodes: base RV32I major opcodes (bits [6:0] of the instruction word).
package rv32i_opcodes;
    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        OP_IMM   = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORE    = 7'b0100011,
        OP       = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } rv32i_opcode_t;
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: run/opcode into the controller, control strobes out to the datapath.
interface control_fsm_if;
    logic       run;
    logic [6:0] opcode;
    logic       ir_wren;
    logic       pc_inc;
    logic       regfile_wren;
    logic       alu_src_imm;
    modport master (input run, opcode, output ir_wren, pc_inc, regfile_wren, alu_src_imm);
    modport slave  (output run, opcode, input ir_wren, pc_inc, regfile_wren, alu_src_imm);
endinterface

// File: rtl/perf_counter.sv
// perf_counter: free-running wrap-around event counter.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (clear || inc) count <= clear ? '0 : count + 1'b1;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I controller sequencing fetch/decode/execute/writeback
// with memory wait states, halt/trap terminal states and performance counters.
module control_fsm
    import ctrl_pkg::*;
    import rv32i_opcodes::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    control_fsm_if.master        bus,
    output logic                 halted,
    output logic                 illegal_instr,
    output ctrl_state_t          state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret
);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY - 1);
    ctrl_state_t       state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              alu_imm_q;
    logic              active, retire;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            alu_imm_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == S_DECODE) alu_imm_q <= bus.opcode == OP_IMM;
        end
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            S_IDLE: if (bus.run) begin
                state_nxt = S_FETCH;
                wait_nxt  = WAIT_INIT;
            end
            S_FETCH: if (wait_cnt != '0) wait_nxt = wait_cnt - 1'b1;
                     else state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (bus.opcode == OP || bus.opcode == OP_IMM) ? S_EXEC :
                                  (bus.opcode == SYSTEM) ? S_HALT : S_TRAP;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                state_nxt = bus.run ? S_FETCH : S_IDLE;
                wait_nxt  = bus.run ? WAIT_INIT : wait_cnt;
            end
            default: state_nxt = state;
        endcase
    end
    // Moore strobes: decoded from the state register only
    assign bus.ir_wren      = state == S_LATCH;
    assign bus.pc_inc       = state == S_LATCH;
    assign bus.regfile_wren = state == S_WB;
    assign bus.alu_src_imm  = alu_imm_q;
    assign halted           = state == S_HALT;
    assign illegal_instr    = state == S_TRAP;
    assign active = state inside {S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_WB};
    assign retire = state == S_WB || (state == S_DECODE && bus.opcode == SYSTEM);
    perf_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
        .clk(clk), .rst(rst), .clear(1'b0), .inc(active), .count(cycle_count)
    );
    perf_counter #(.WIDTH(CNT_WIDTH)) u_instret (
        .clk(clk), .rst(rst), .clear(1'b0), .inc(retire), .count(instret)
    );
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench over three controller configurations
// (ML=1, ML=3, ML=1 with 4-bit counters).
module tb_control_fsm;
    import ctrl_pkg::*;
    import rv32i_opcodes::*;

    typedef struct {
        logic        run;
        logic [6:0]  opc;
        ctrl_state_t st;
        logic        ir, pc, rf, alu, hlt, ill;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    ctrl_state_t st0, st1, st2;
    logic        h0, h1, h2, i0, i1, i2;
    logic [31:0] cc0, cc1, ir0, ir1;
    logic [3:0]  cc2, ir2;
    int          n_vec = 0, n_err = 0;
    vec_t        sb[$];

    control_fsm_if bus0 ();
    control_fsm_if bus1 ();
    control_fsm_if bus2 ();

    control_fsm #(.MEM_LATENCY(1), .CNT_WIDTH(32)) u0 (
        .clk(clk), .rst(rst_v[0]), .bus(bus0), .halted(h0), .illegal_instr(i0),
        .state(st0), .cycle_count(cc0), .instret(ir0));
    control_fsm #(.MEM_LATENCY(3), .CNT_WIDTH(32)) u1 (
        .clk(clk), .rst(rst_v[1]), .bus(bus1), .halted(h1), .illegal_instr(i1),
        .state(st1), .cycle_count(cc1), .instret(ir1));
    control_fsm #(.MEM_LATENCY(1), .CNT_WIDTH(4)) u2 (
        .clk(clk), .rst(rst_v[2]), .bus(bus2), .halted(h2), .illegal_instr(i2),
        .state(st2), .cycle_count(cc2), .instret(ir2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pack(input vec_t v);
        return {v.st, v.ir, v.pc, v.rf, v.alu, v.hlt, v.ill};
    endfunction

    function automatic vec_t obs(input int u);
        vec_t v;
        v.run = 1'b0;
        v.opc = '0;
        case (u)
            0: begin v.st = st0; v.ir = bus0.ir_wren; v.pc = bus0.pc_inc; v.rf = bus0.regfile_wren;
                     v.alu = bus0.alu_src_imm; v.hlt = h0; v.ill = i0; end
            1: begin v.st = st1; v.ir = bus1.ir_wren; v.pc = bus1.pc_inc; v.rf = bus1.regfile_wren;
                     v.alu = bus1.alu_src_imm; v.hlt = h1; v.ill = i1; end
            default: begin v.st = st2; v.ir = bus2.ir_wren; v.pc = bus2.pc_inc; v.rf = bus2.regfile_wren;
                     v.alu = bus2.alu_src_imm; v.hlt = h2; v.ill = i2; end
        endcase
        return v;
    endfunction

    function automatic logic [31:0] cyc(input int u);
        return u == 0 ? cc0 : u == 1 ? cc1 : {28'd0, cc2};
    endfunction

    function automatic logic [31:0] ret(input int u);
        return u == 0 ? ir0 : u == 1 ? ir1 : {28'd0, ir2};
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic drive(input int u, input logic r, input logic [6:0] o);
        case (u)
            0: begin bus0.run = r; bus0.opcode = o; end
            1: begin bus1.run = r; bus1.opcode = o; end
            default: begin bus2.run = r; bus2.opcode = o; end
        endcase
    endtask

    // expected outputs for the cycle, plus the inputs to apply during it
    task automatic push(input logic r, input logic [6:0] o, input ctrl_state_t s, input logic alu,
                        input logic hlt = 1'b0, input logic ill = 1'b0);
        vec_t v;
        v.run = r; v.opc = o; v.st = s; v.alu = alu; v.hlt = hlt; v.ill = ill;
        v.ir = s == S_LATCH; v.pc = s == S_LATCH; v.rf = s == S_WB;
        sb.push_back(v);
    endtask

    task automatic push_instr(input int ml, input logic [6:0] o, input logic a0, input logic a1,
                              input logic rx = 1'b1, input logic rw = 1'b1);
        for (int i = 0; i < ml; i++) push(1'b1, junk(), S_FETCH, a0);
        push(1'b1, junk(), S_LATCH, a0);
        push(1'b1, o, S_DECODE, a0);
        push(rx, junk(), S_EXEC, a1);
        push(rw, junk(), S_WB, a1);
    endtask

    // called at a negedge; returns at the negedge after the last entry
    task automatic play(input int u);
        int idx = 0;
        vec_t e, g;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = obs(u);
            check($sformatf("u%0d_c%0d_%s", u, idx, e.st.name()), {23'd0, pack(g)}, {23'd0, pack(e)});
            drive(u, e.run, e.opc);
            idx++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t g;
        rst_v = '1;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, '0);
        #1 rst_v = '0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset_out_u%0d", u), {23'd0, pack(obs(u))}, 32'd0);
            check($sformatf("reset_cnt_u%0d", u), cyc(u) | ret(u), 32'd0);
        end
        rst_v = '1;

        // three OP instructions back to back, opcode scrambled outside DECODE
        push(1'b1, junk(), S_IDLE, 1'b0);
        repeat (3) push_instr(1, OP, 1'b0, 1'b0);
        play(0);
        check("u0_cycles_3instr", cyc(0), 32'd15);
        check("u0_instret_3instr", ret(0), 32'd3);
        // run dropped during EXEC: WB completes, then parks idle
        push_instr(1, OP, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) push(1'b0, junk(), S_IDLE, 1'b0);
        play(0);
        check("u0_cycles_idle", cyc(0), 32'd20);
        check("u0_instret_idle", ret(0), 32'd4);
        // SYSTEM halts and retires
        push(1'b1, junk(), S_IDLE, 1'b0);
        push(1'b1, junk(), S_FETCH, 1'b0);
        push(1'b1, junk(), S_LATCH, 1'b0);
        push(1'b1, SYSTEM, S_DECODE, 1'b0);
        repeat (5) push(1'($urandom_range(0, 1)), junk(), S_HALT, 1'b0, 1'b1, 1'b0);
        play(0);
        check("u0_instret_halt", ret(0), 32'd5);
        check("u0_cycles_halt", cyc(0), 32'd23);
        #2 rst_v[0] = 1'b0;
        #1 check("u0_halt_reset_out", {23'd0, pack(obs(0))}, 32'd0);
        check("u0_halt_reset_cnt", cyc(0) | ret(0), 32'd0);
        @(negedge clk) rst_v[0] = 1'b1;

        // ML=3: OP_IMM then unsupported LOAD traps
        push(1'b1, junk(), S_IDLE, 1'b0);
        push_instr(3, OP_IMM, 1'b0, 1'b1);
        repeat (3) push(1'b1, junk(), S_FETCH, 1'b1);
        push(1'b1, junk(), S_LATCH, 1'b1);
        push(1'b1, LOAD, S_DECODE, 1'b1);
        repeat (20) push(1'($urandom_range(0, 1)), junk(), S_TRAP, 1'b0, 1'b0, 1'b1);
        play(1);
        check("u1_instret_trap", ret(1), 32'd1);
        check("u1_cycles_frozen", cyc(1), 32'd12);

        // asynchronous reset between edges while in LATCH
        push(1'b1, junk(), S_IDLE, 1'b0);
        push(1'b1, junk(), S_FETCH, 1'b0);
        play(2);
        g = obs(2);
        check("u2_latch_ir", {31'd0, g.ir & g.pc}, 32'd1);
        #2 rst_v[2] = 1'b0;
        #1 g = obs(2);
        check("u2_async_out", {23'd0, pack(g)}, 32'd0);
        check("u2_async_cnt", cyc(2) | ret(2), 32'd0);
        @(negedge clk) rst_v[2] = 1'b1;
        // 17 instructions on 4-bit counters: instret wraps to 1
        push(1'b1, junk(), S_IDLE, 1'b0);
        repeat (16) push_instr(1, OP, 1'b0, 1'b0);
        push_instr(1, OP, 1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b0, junk(), S_IDLE, 1'b0);
        play(2);
        check("u2_instret_wrap", ret(2), 32'd1);
        check("u2_cycles_wrap", cyc(2), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
